pipe_ctrl: RTL

Pipeline control unit for the five-stage MIPS32 core. It merges stall requests from ID and EX into the 6-bit `stall` vector consumed by the PC register and the stage registers. It sequences exception entry and `eret` return by issuing one-cycle flush pulses with a redirect address to the PC register. It also keeps the EPC and a saturating stall-cycle counter.

---
 rtl/pipe_ctrl_pkg.sv | 25 ++
 rtl/pipe_ctrl_sat_counter.sv | 21 ++
 rtl/pipe_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit.
// Stall bit indices, stall encodings, FSM states.
package pipe_ctrl_pkg;

    localparam int STALL_PC    = 0;
    localparam int STALL_IF_ID = 1;
    localparam int STALL_ID_EX = 2;
    localparam int STALL_EX_MEM = 3;
    localparam int STALL_MEM_WB = 4;
    localparam int STALL_WB    = 5;

    localparam logic [5:0] StallEx   = 6'b001111;
    localparam logic [5:0] StallId   = 6'b000111;
    localparam logic [5:0] StallNone = 6'b000000;

    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0020;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        FLUSH_EXC = 2'd1,
        HANDLER   = 2'd2,
        FLUSH_RET = 2'd3
    } state_t;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter; holds at all-ones.
// Asynchronous active-low reset.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc, stop at the maximum value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && !(&count)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall merge, exception/eret flush
// sequencing, EPC and stall-cycle counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             exc_req,
    input  logic [31:0]      exc_epc,
    input  logic             eret_req,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic [31:0]      epc,
    output logic             in_exc,
    output logic [CNT_W-1:0] stall_cycles
);

    logic [1:0]  rst_sync;
    logic        rst_i;
    state_t      state;
    state_t      state_nx;
    logic        flush_nx;
    logic [31:0] new_pc_nx;

    // Assert reset immediately, release it two edges later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_i = rst_sync[1];

    // Next state and the registered flush/redirect values.
    always_comb begin
        state_nx  = state;
        flush_nx  = 1'b0;
        new_pc_nx = '0;
        unique case (state)
            RUN: begin
                if (exc_req) begin
                    state_nx = FLUSH_EXC;
                end
            end
            FLUSH_EXC: begin
                state_nx = HANDLER;
            end
            HANDLER: begin
                if (eret_req) begin
                    state_nx = FLUSH_RET;
                end
            end
            FLUSH_RET: begin
                state_nx = RUN;
            end
            default: begin
                state_nx = RUN;
            end
        endcase
        if (state_nx == FLUSH_EXC) begin
            flush_nx  = 1'b1;
            new_pc_nx = EXC_VECTOR;
        end else if (state_nx == FLUSH_RET) begin
            flush_nx  = 1'b1;
            new_pc_nx = epc;
        end
    end

    // State, flush pulse, redirect, exception flag and EPC.
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            state  <= RUN;
            flush  <= 1'b0;
            new_pc <= '0;
            in_exc <= 1'b0;
            epc    <= '0;
        end else begin
            state  <= state_nx;
            flush  <= flush_nx;
            new_pc <= new_pc_nx;
            in_exc <= (state_nx != RUN);
            if (state == RUN && exc_req) begin
                epc <= exc_epc;
            end
        end
    end

    // Stall merge: EX outranks ID; reset and flush suppress it.
    always_comb begin
        stall = StallNone;
        if (rst_i && !flush) begin
            if (stallreq_ex) begin
                stall = StallEx;
            end else if (stallreq_id) begin
                stall = StallId;
            end
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst_i),
        .inc  (stall[STALL_PC]),
        .count(stall_cycles)
    );

endmodule
